// File: rtl/dm_cache_pkg.sv
// Shared LC-3b types for the direct-mapped cache: word, write mask, line,
// tag/index/offset fields, FSM states and the CPU-write byte-mask helper.
package dm_cache_pkg;

  localparam int C_INDEX_BITS = 3;
  localparam int OFFSET_BITS  = 4;
  localparam int LINE_BYTES   = 16;
  localparam int C_TAG_BITS   = 12 - C_INDEX_BITS;

  typedef logic [15:0]               lc3b_word;
  typedef logic [1:0]                lc3b_mem_wmask;
  typedef logic [127:0]              lc3b_cache_line;
  typedef logic [C_TAG_BITS-1:0]     lc3b_c_tag;
  typedef logic [C_INDEX_BITS-1:0]   lc3b_c_index;
  typedef logic [OFFSET_BITS-1:0]    lc3b_c_offset;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } cache_state_e;

  // Expands a 2-bit word write mask into a 16-bit line byte mask for word 'word'.
  function automatic logic [LINE_BYTES-1:0] wordByteMask(input logic [2:0] word,
                                                         input lc3b_mem_wmask be);
    logic [LINE_BYTES-1:0] mask;
    mask = '0;
    for (int w = 0; w < 8; w++) begin
      if (3'(w) == word) begin
        mask[2*w]   = be[0];
        mask[2*w+1] = be[1];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Per-set storage for the direct-mapped cache: line data, tag, valid and dirty.
// Reads are combinational on 'index'; all writes land on the rising clock edge.
// Only valid and dirty are cleared by reset; data and tags keep stale contents.
module cache_array
  import dm_cache_pkg::*;
#(
  parameter int INDEX_BITS = C_INDEX_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [INDEX_BITS-1:0]       index,
  input  logic                        loadData,
  input  logic                        loadTag,
  input  logic [LINE_BYTES-1:0]       byteMask,
  input  lc3b_cache_line              dataIn,
  input  logic [12-INDEX_BITS-1:0]    tagIn,
  input  logic                        setValid,
  input  logic                        clearValid,
  input  logic                        setDirty,
  input  logic                        clearDirty,
  output lc3b_cache_line              lineOut,
  output logic [12-INDEX_BITS-1:0]    tagOut,
  output logic                        validOut,
  output logic                        dirtyOut
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = 12 - INDEX_BITS;

  lc3b_cache_line            data_q [SETS];
  logic [TAG_BITS-1:0]       tag_q  [SETS];
  logic [SETS-1:0]           valid_q;
  logic [SETS-1:0]           dirty_q;

  // Line data and tag writes: a fill replaces the whole line, a CPU write merges bytes.
  always_ff @(posedge clk) begin
    if (loadData) begin
      data_q[index] <= dataIn;
    end else begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (byteMask[b]) begin
          data_q[index][8*b +: 8] <= dataIn[8*b +: 8];
        end
      end
    end
    if (loadTag) begin
      tag_q[index] <= tagIn;
    end
  end

  // Valid and dirty bits, cleared by reset so a cold cache never reports a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (setValid) begin
        valid_q[index] <= 1'b1;
      end else if (clearValid) begin
        valid_q[index] <= 1'b0;
      end
      if (setDirty) begin
        dirty_q[index] <= 1'b1;
      end else if (clearDirty) begin
        dirty_q[index] <= 1'b0;
      end
    end
  end

  assign lineOut  = data_q[index];
  assign tagOut   = tag_q[index];
  assign validOut = valid_q[index];
  assign dirtyOut = dirty_q[index];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache for the LC-3b multicycle core.
// Hits answer in the request cycle; misses write back a dirty victim, fill the
// line from physical memory, then hit. The CPU holds its request until mem_resp,
// so the FSM works directly off the live address and latches nothing.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int INDEX_BITS = C_INDEX_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mem_read,
  input  logic           mem_write,
  input  lc3b_mem_wmask  mem_byte_enable,
  input  lc3b_word       mem_address,
  input  lc3b_word       mem_wdata,
  output logic           mem_resp,
  output lc3b_word       mem_rdata,
  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_word       pmem_address,
  output lc3b_cache_line pmem_wdata,
  input  lc3b_cache_line pmem_rdata,
  input  logic           pmem_resp
);

  localparam int TAG_BITS = 12 - INDEX_BITS;

  cache_state_e state_q, state_d;

  logic [TAG_BITS-1:0]    reqTag;
  logic [INDEX_BITS-1:0]  reqIndex;
  logic [2:0]             wordSel;
  logic                   unusedAddrBit;
  logic                   reqActive;
  logic                   hit;

  lc3b_cache_line         lineRd;
  logic [TAG_BITS-1:0]    tagRd;
  logic                   validRd;
  logic                   dirtyRd;

  logic                   loadData;
  logic                   loadTag;
  logic                   setValid;
  logic                   setDirty;
  logic                   clearDirty;
  logic [LINE_BYTES-1:0]  byteMask;
  lc3b_cache_line         wrData;

  assign reqTag        = mem_address[15 -: TAG_BITS];
  assign reqIndex      = mem_address[OFFSET_BITS +: INDEX_BITS];
  assign wordSel       = mem_address[3:1];
  assign unusedAddrBit = mem_address[0];
  assign reqActive     = mem_read | mem_write;
  assign hit           = validRd && (tagRd == reqTag);

  assign wrData    = loadData ? pmem_rdata : {8{mem_wdata}};
  assign mem_rdata = lineRd[{wordSel, 4'b0000} +: 16];

  cache_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (reqIndex),
    .loadData   (loadData),
    .loadTag    (loadTag),
    .byteMask   (byteMask),
    .dataIn     (wrData),
    .tagIn      (reqTag),
    .setValid   (setValid),
    .clearValid (1'b0),
    .setDirty   (setDirty),
    .clearDirty (clearDirty),
    .lineOut    (lineRd),
    .tagOut     (tagRd),
    .validOut   (validRd),
    .dirtyOut   (dirtyRd)
  );

  // FSM state register; reset abandons any miss in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, hit response, array write controls and pmem handshake.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = lineRd;
    loadData     = 1'b0;
    loadTag      = 1'b0;
    setValid     = 1'b0;
    setDirty     = 1'b0;
    clearDirty   = 1'b0;
    byteMask     = '0;

    case (state_q)
      IDLE: begin
        if (reqActive) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              byteMask = wordByteMask(wordSel, mem_byte_enable);
              setDirty = 1'b1;
            end
          end else if (validRd && dirtyRd) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tagRd, reqIndex, 4'b0000};
        if (pmem_resp) begin
          clearDirty = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {reqTag, reqIndex, 4'b0000};
        if (pmem_resp) begin
          loadData   = 1'b1;
          loadTag    = 1'b1;
          setValid   = 1'b1;
          clearDirty = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: a behavioural physical memory answers every
// pmem request three cycles after it appears, and a linear sequence of CPU
// requests is checked against hand-computed data and latencies.
module tb_dm_cache;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int nAsserts = 0;
  int nFails   = 0;

  int           readCount     = 0;
  int           writeCount    = 0;
  int           eventSeq      = 0;
  int           lastReadSeq   = 0;
  int           lastWriteSeq  = 0;
  logic [15:0]  lastReadAddr  = '0;
  logic [15:0]  lastWriteAddr = '0;
  logic [127:0] lastWriteData = '0;

  int   respCycles;
  logic sawResp;

  dm_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory image: a few recognisable lines, everything else 0xA5A5.
  function automatic logic [127:0] memLine(input logic [15:0] a);
    logic [127:0] l;
    logic [15:0]  base;
    case (a)
      16'h0010: base = 16'h1000;
      16'h0090: base = 16'h2000;
      16'h0020: base = 16'h3000;
      default:  base = 16'hA5A5;
    endcase
    for (int w = 0; w < 8; w++) begin
      l[16*w +: 16] = (base == 16'hA5A5) ? base : base + 16'(w);
    end
    if (a == 16'h0010) l[31:16] = 16'hBEEF;
    if (a == 16'h0090) l[31:16] = 16'hCAFE;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] be,
                               input logic [15:0] addr, input logic [15:0] wdata);
    @(posedge clk);
    #1;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wdata;
  endtask

  task automatic releaseRequest();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Counts falling edges seen without mem_resp; gives up after 60.
  task automatic waitForResp(output int cycles);
    cycles = 0;
    while (cycles < 60) begin
      @(negedge clk);
      if (mem_resp === 1'b1) break;
      cycles++;
    end
  endtask

  // Memory responder: answers three cycles after a request appears, for one cycle.
  initial begin
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        cnt       = 0;
        pmem_resp = 1'b0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end else if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
        cnt++;
        if (cnt == 3) begin
          pmem_resp = 1'b1;
          eventSeq++;
          if (pmem_read === 1'b1) begin
            pmem_rdata   = memLine(pmem_address);
            readCount++;
            lastReadAddr = pmem_address;
            lastReadSeq  = eventSeq;
          end else begin
            writeCount++;
            lastWriteAddr = pmem_address;
            lastWriteData = pmem_wdata;
            lastWriteSeq  = eventSeq;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Watchdog in case the directed sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst_n           = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_resp",   mem_resp,     1'b0);
    checkOutput("reset_pmem_read",  pmem_read,    1'b0);
    checkOutput("reset_pmem_write", pmem_write,   1'b0);
    checkOutput("reset_pmem_addr",  pmem_address, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold read miss: fill of line 0x0010, then hit one cycle after pmem_resp.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0012, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t1_latency",    respCycles, 4);
    checkOutput("t1_rdata",      mem_rdata, 16'hBEEF);
    checkOutput("t1_fill_count", readCount, 1);
    checkOutput("t1_fill_addr",  lastReadAddr, 16'h0010);
    checkOutput("t1_no_wb",      writeCount, 0);
    releaseRequest();

    // Read hit in the request cycle.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t2_latency",   respCycles, 0);
    checkOutput("t2_rdata",     mem_rdata, 16'h1000);
    checkOutput("t2_pmem_read", pmem_read, 1'b0);
    releaseRequest();
    checkOutput("t2_no_fill",   readCount, 1);

    // Write hits: low byte, high byte, and an empty byte mask.
    applyStimulus(1'b0, 1'b1, 2'b01, 16'h0012, 16'h1234);
    waitForResp(respCycles);
    checkOutput("t3_wr_lo_latency", respCycles, 0);
    releaseRequest();
    applyStimulus(1'b0, 1'b1, 2'b10, 16'h001E, 16'hAB99);
    waitForResp(respCycles);
    checkOutput("t3_wr_hi_latency", respCycles, 0);
    releaseRequest();
    applyStimulus(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF);
    waitForResp(respCycles);
    checkOutput("t3_wr_none_latency", respCycles, 0);
    releaseRequest();
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0012, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t3_rd_word1", mem_rdata, 16'hBE34);
    releaseRequest();
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h001E, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t3_rd_word7", mem_rdata, 16'hAB07);
    releaseRequest();
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t3_rd_word0", mem_rdata, 16'h1000);
    releaseRequest();

    // Conflict miss on index 1: dirty victim written back, then fill of 0x0090.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0092, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t4_latency",   respCycles, 8);
    checkOutput("t4_rdata",     mem_rdata, 16'hCAFE);
    checkOutput("t4_wb_count",  writeCount, 1);
    checkOutput("t4_wb_addr",   lastWriteAddr, 16'h0010);
    checkOutput("t4_wb_word1",  lastWriteData[31:16], 16'hBE34);
    checkOutput("t4_wb_word7",  lastWriteData[127:112], 16'hAB07);
    checkOutput("t4_wb_word0",  lastWriteData[15:0], 16'h1000);
    checkOutput("t4_wb_first",  (lastWriteSeq < lastReadSeq), 1'b1);
    checkOutput("t4_fill_addr", lastReadAddr, 16'h0090);
    checkOutput("t4_fill_count", readCount, 2);
    releaseRequest();

    // Reset two cycles into a fill.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0024, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t5_filling",      pmem_read, 1'b1);
    checkOutput("t5_filling_addr", pmem_address, 16'h0020);
    rst_n    = 1'b0;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_pmem_read",  pmem_read, 1'b0);
    checkOutput("t5_rst_pmem_write", pmem_write, 1'b0);
    rst_n = 1'b1;
    checkOutput("t5_no_fill_done", readCount, 2);
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0024, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t5_refill_latency", respCycles, 4);
    checkOutput("t5_refill_rdata",   mem_rdata, 16'h3002);
    checkOutput("t5_refill_count",   readCount, 3);
    checkOutput("t5_refill_addr",    lastReadAddr, 16'h0020);
    releaseRequest();
    // Reset also invalidated line 0x0090: clean miss, no writeback.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0092, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t5_inval_latency", respCycles, 4);
    checkOutput("t5_inval_rdata",   mem_rdata, 16'hCAFE);
    checkOutput("t5_inval_no_wb",   writeCount, 1);
    releaseRequest();

    // Request dropped during fill: fill completes silently, then hits.
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0034, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("t6_filling", pmem_read, 1'b1);
    #1;
    mem_read = 1'b0;
    sawResp  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_resp === 1'b1) sawResp = 1'b1;
    end
    checkOutput("t6_no_resp",    sawResp, 1'b0);
    checkOutput("t6_fill_done",  readCount, 5);
    checkOutput("t6_idle_read",  pmem_read, 1'b0);
    checkOutput("t6_idle_write", pmem_write, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0034, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t6_hit_latency", respCycles, 0);
    checkOutput("t6_hit_rdata",   mem_rdata, 16'hA5A5);
    releaseRequest();

    // Read and write together behave as a write.
    applyStimulus(1'b1, 1'b1, 2'b11, 16'h0034, 16'h4321);
    waitForResp(respCycles);
    checkOutput("t7_rw_latency", respCycles, 0);
    releaseRequest();
    applyStimulus(1'b1, 1'b0, 2'b00, 16'h0034, 16'h0000);
    waitForResp(respCycles);
    checkOutput("t7_rw_rdata", mem_rdata, 16'h4321);
    releaseRequest();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the LC-3b multicycle core's memory port and physical memory.
- CPU side speaks the core's existing word protocol: level read/write, hold until resp.
- Memory side moves whole 128-bit lines with a read/write/resp handshake.
- Hits complete in the request cycle; misses write back a dirty victim if needed, then fill, then hit.

Parameters:
INDEX_BITS, 3, set index width; sets = 2^INDEX_BITS (8). Tag width = 12 - INDEX_BITS.
OFFSET_BITS, 4, fixed byte offset within a 16-byte line; not overridable.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  2  lc3b_mem_wmask; bit0 = low byte, bit1 = high byte
mem_address  in  16  lc3b_word byte address; bit0 ignored for word select
mem_wdata  in  16  lc3b_word write data
mem_resp  out  1  request complete this cycle
mem_rdata  out  16  lc3b_word read data, valid when mem_resp
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_address  out  16  line-aligned address, bits[3:0] = 0
pmem_wdata  out  128  victim line data
pmem_rdata  in  128  fill line data
pmem_resp  in  1  physical memory done

Behaviour:
- Address split: tag = addr[15:4+INDEX_BITS], index = addr[3+INDEX_BITS:4], word = addr[3:1]. Line word w occupies bits [16w+15:16w].
- Reset (rst_n=0 at edge):
  - state := IDLE; all valid and dirty bits := 0.
  - Tag and data arrays are not reset.
  - Outputs in IDLE with no request: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=don't-care.
  - mem_rdata is don't-care when mem_resp=0.
- States: IDLE, WRITEBACK, FILL.
- IDLE, request and hit (valid[index] && tag match):
  - mem_resp=1 combinationally, same cycle.
  - Read: mem_rdata = selected word.
  - Write: at the edge, write the enabled bytes of the selected word and set dirty[index]=1. byte_enable=00 changes no data but still sets dirty.
- IDLE, request and miss:
  - mem_resp=0.
  - valid && dirty: next state WRITEBACK; otherwise next state FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag, index, 4'b0}, pmem_wdata=stored line, all held stable.
  - On pmem_resp: dirty[index]:=0, next state FILL.
- FILL:
  - pmem_read=1, pmem_address={request tag, index, 4'b0}.
  - On pmem_resp: data[index]:=pmem_rdata, tag:=request tag, valid:=1, dirty:=0, next state IDLE.
  - The request then hits in the following cycle. Clean read-miss latency is fill latency + 1 cycle.
- pmem_read and pmem_write are never both 1. Both are 0 in IDLE.
- mem_read and mem_write both 1 is illegal from the core; the cache treats it as a write.
- Request dropped mid-miss: the current WRITEBACK/FILL completes, then the FSM returns to IDLE. No mem_resp is issued.
- Request address must be stable from assertion to mem_resp. The FSM latches nothing from the CPU side.
- Reset mid-miss: FSM goes to IDLE at that edge and pmem_* deassert. Any line being filled stays invalid.
- pmem_resp while in IDLE is ignored.

Decomposition:
- Add to lc3b_types:
  - lc3b_cache_line (logic [127:0])
  - lc3b_c_tag, lc3b_c_index, lc3b_c_offset typedefs
  - localparam LINE_BYTES = 16
- Sub-module cache_array: per-set data, tag, valid and dirty storage.
  - Inputs: index, load_data, load_tag, set/clear valid, set/clear dirty, per-byte write mask.
  - Behaviour: combinational read, synchronous write.
- dm_cache holds the FSM, hit compare, word/byte merge and pmem muxing.

Test Plan:
1. Cold read 0x0012:
   - stimulus: pmem returns a line with word1 = 0xBEEF after 3 cycles.
   - required: pmem_read with pmem_address 0x0010 and no writeback.
   - required: mem_resp with mem_rdata=0xBEEF one cycle after pmem_resp.
2. Read-hit latency after test 1:
   - stimulus: read 0x0010.
   - required: mem_resp=1 in the request cycle and no pmem activity.
3. Write hit 0x0012, byte_enable=01, wdata=0x1234:
   - required: mem_resp the same cycle.
   - required: a subsequent read 0x0012 returns 0xBE34, and dirty is set.
4. Conflict read 0x0092 (same index 1, tag differs) after test 3:
   - required: WRITEBACK first, with pmem_address=0x0010 and pmem_wdata word1=0xBE34.
   - required: then FILL at 0x0090, then mem_resp.
5. Reset mid-FILL:
   - stimulus: rst_n=0 two cycles into a fill.
   - required: pmem_read=0 after the edge.
   - required: a re-read of the same address misses again (fill reissued).
6. Request dropped mid-miss:
   - stimulus: mem_read deasserted during FILL.
   - required: the fill completes and the FSM returns to IDLE with no mem_resp.
   - required: the next read of that address hits the same cycle.
